// File: rtl/alu_mul_seq.sv
// alu_mul_seq -- sequential 8x8 shift-and-add multiplier that borrows a
// shared external ALU, one ALU operation per clock.
//
// Ports:
//   Clk      clock, all state updates on the rising edge
//   Reset    synchronous, active-high reset
//   Start    request pulse, only sampled while idle
//   MulA     multiplicand, captured when Start is accepted
//   MulB     multiplier, captured when Start is accepted
//   Busy     high in every state except idle
//   Done     one-cycle completion pulse
//   Product  low 8 bits of MulA*MulB, held until the next completion
//   AluA     shared ALU operand A
//   AluB     shared ALU operand B
//   AluOp    shared ALU opcode (kADD, kLSL, kLSR only)
//   AluOut   ALU result, combinational from this cycle's AluA/AluB/AluOp
//   AluZero  ALU zero flag for this cycle
//
// Build option:
//   ALU_SEQ_EARLY_EXIT_EN  finish as soon as the multiplier shifts to zero
//                          instead of always running eight iterations.

package alu_defs_pkg;
  localparam logic [2:0] kADD = 3'd0;
  localparam logic [2:0] kLSL = 3'd4;
  localparam logic [2:0] kLSR = 3'd5;
endpackage

module alu_mul_seq
  import alu_defs_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [7:0] MulA,
  input  logic [7:0] MulB,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] Product,
  output logic [7:0] AluA,
  output logic [7:0] AluB,
  output logic [2:0] AluOp,
  input  logic [7:0] AluOut,
  input  logic       AluZero
);

  localparam logic [2:0] st_idle = 3'd0;
  localparam logic [2:0] st_add  = 3'd1;
  localparam logic [2:0] st_shl  = 3'd2;
  localparam logic [2:0] st_shr  = 3'd3;
  localparam logic [2:0] st_done = 3'd4;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [7:0] p;
  logic [7:0] m;
  logic [7:0] q;
  logic [2:0] cnt;
  logic       last_iter;

`ifdef ALU_SEQ_EARLY_EXIT_EN
  // In SHR the ALU output is the shifted multiplier, so the zero flag
  // says no set bits remain and further iterations cannot change P.
  assign last_iter = AluZero;
`else
  logic unused_alu_zero;
  assign unused_alu_zero = AluZero;
  assign last_iter       = (cnt == 3'd7);
`endif

  assign Busy = (state != st_idle);
  assign Done = (state == st_done);

  always_comb begin
    state_nxt = state;
    AluOp     = kADD;
    AluA      = '0;
    AluB      = '0;
    case (state)
      st_idle: if (Start) state_nxt = st_add;
      st_add: begin
        AluOp     = kADD;
        AluA      = p;
        AluB      = m;
        state_nxt = st_shl;
      end
      st_shl: begin
        AluOp     = kLSL;
        AluA      = m;
        state_nxt = st_shr;
      end
      st_shr: begin
        AluOp     = kLSR;
        AluA      = q;
        state_nxt = last_iter ? st_done : st_add;
      end
      st_done: state_nxt = st_idle;
      default: state_nxt = st_idle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= st_idle;
      p       <= '0;
      m       <= '0;
      q       <= '0;
      cnt     <= '0;
      Product <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        st_idle: begin
          if (Start) begin
            m   <= MulA;
            q   <= MulB;
            p   <= '0;
            cnt <= '0;
          end
        end
        st_add: if (q[0]) p <= AluOut;
        st_shl: m <= AluOut;
        st_shr: begin
          q   <= AluOut;
          cnt <= cnt + 3'd1;
          // P is final once the last ADD has run, so Product is loaded on
          // the SHR->DONE edge and is already valid while Done is high.
          if (last_iter) Product <= p;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq with a behavioural model of the
// shared ALU and a scoreboard of expected products and latencies.
module tb_alu_mul_seq;
  import alu_defs_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [7:0] MulA;
  logic [7:0] MulB;
  logic       Busy;
  logic       Done;
  logic [7:0] Product;
  logic [7:0] AluA;
  logic [7:0] AluB;
  logic [2:0] AluOp;
  logic [7:0] AluOut;
  logic       AluZero;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  int         lat_q[$];

  alu_mul_seq dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .MulA(MulA), .MulB(MulB),
    .Busy(Busy), .Done(Done), .Product(Product), .AluA(AluA), .AluB(AluB),
    .AluOp(AluOp), .AluOut(AluOut), .AluZero(AluZero)
  );

  always #5 Clk = ~Clk;

  // Shared ALU model: shifts are by one position.
  always_comb begin
    AluOut = '0;
    case (AluOp)
      kADD: AluOut = AluA + AluB;
      kLSL: AluOut = {AluA[6:0], 1'b0};
      kLSR: AluOut = {1'b0, AluA[7:1]};
      default: AluOut = 8'hxx;
    endcase
    AluZero = (AluOut == 8'd0);
  end

  // Cycles from the Start edge to the end of the Done cycle.
  function automatic int exp_latency(input logic [7:0] b);
`ifdef ALU_SEQ_EARLY_EXIT_EN
    int iters;
    iters = 1;
    for (int i = 0; i < 8; i++) if (b[i]) iters = i + 1;
    return 3 * iters + 1;
`else
    return 25;
`endif
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input bit noise, input bit poke_done);
    int k;
    bit seq_ok;
    logic [15:0] full;
    logic [7:0] ep;
    int el;
    logic [2:0] want;
    full = 16'(a) * 16'(b);
    exp_q.push_back(full[7:0]);
    lat_q.push_back(exp_latency(b));
    MulA = a; MulB = b; Start = 1'b1;
    tick();
    n_checks++;
    if (Busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_after_start a=%0d b=%0d got=%b want=1", a, b, Busy);
    end
    k = 0; seq_ok = 1'b1;
    while (Done !== 1'b1 && k < 80) begin
      want = (k % 3 == 0) ? kADD : ((k % 3 == 1) ? kLSL : kLSR);
      if (AluOp !== want) seq_ok = 1'b0;
      if (noise) begin
        Start = 1'($urandom_range(0, 1));
        MulA  = 8'($urandom);
        MulB  = 8'($urandom);
      end else begin
        Start = 1'b0;
      end
      tick();
      k++;
    end
    ep = exp_q.pop_front();
    el = lat_q.pop_front();
    n_checks++;
    if (Done !== 1'b1) begin
      n_fail++; $display("FAIL done_timeout a=%0d b=%0d got=no Done want=Done within 80 cycles", a, b);
    end else begin
      n_checks++;
      if (Product !== ep) begin
        n_fail++; $display("FAIL product a=%0d b=%0d got=%0d want=%0d", a, b, Product, ep);
      end
      n_checks++;
      if (k + 1 != el) begin
        n_fail++; $display("FAIL latency a=%0d b=%0d got=%0d want=%0d", a, b, k + 1, el);
      end
      n_checks++;
      if (!seq_ok) begin
        n_fail++; $display("FAIL aluop_sequence a=%0d b=%0d got=out of order want=ADD,LSL,LSR", a, b);
      end
      n_checks++;
      if (AluOp !== kADD || AluA !== 8'd0 || AluB !== 8'd0) begin
        n_fail++; $display("FAIL done_alu_idle got=op%0d/%0d/%0d want=op%0d/0/0", AluOp, AluA, AluB, kADD);
      end
    end
    Start = poke_done; MulA = 8'($urandom); MulB = 8'($urandom);
    tick();
    Start = 1'b0;
    n_checks++;
    if (Done !== 1'b0 || Busy !== 1'b0) begin
      n_fail++; $display("FAIL after_done_idle got=done%b busy%b want=done0 busy0", Done, Busy);
    end
    n_checks++;
    if (Product !== ep) begin
      n_fail++; $display("FAIL product_hold got=%0d want=%0d", Product, ep);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b1; MulA = 8'd3; MulB = 8'd5;
    tick(); tick();
    n_checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Product !== 8'd0) begin
      n_fail++; $display("FAIL reset_outputs got=busy%b done%b prod%0d want=0/0/0", Busy, Done, Product);
    end
    n_checks++;
    if (AluOp !== kADD || AluA !== 8'd0 || AluB !== 8'd0) begin
      n_fail++; $display("FAIL reset_alu got=op%0d/%0d/%0d want=op%0d/0/0", AluOp, AluA, AluB, kADD);
    end
    Start = 1'b0; Reset = 1'b0;
    tick();
    n_checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_idle got=busy%b done%b want=0/0", Busy, Done);
    end
  endtask

  task automatic test_directed();
    run_op(8'd3, 8'd5, 1'b0, 1'b0);
    run_op(8'd16, 8'd20, 1'b0, 1'b0);
    run_op(8'hFF, 8'd0, 1'b0, 1'b0);
    run_op(8'd0, 8'hFF, 1'b0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b0, 1'b0);
    run_op(8'd1, 8'h80, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    // Start is raised during each Done cycle with junk operands; it must be ignored.
    run_op(8'd11, 8'd13, 1'b1, 1'b1);
    run_op(8'd200, 8'd3, 1'b1, 1'b1);
    run_op(8'd9, 8'd1, 1'b0, 1'b0);
  endtask

  task automatic test_start_held();
    int k;
    int dones;
    MulA = 8'd2; MulB = 8'd3; Start = 1'b1;
    tick();
    k = 0; dones = 0;
    while (Done !== 1'b1 && k < 80) begin tick(); k++; end
    if (Done === 1'b1) dones++;
    n_checks++;
    if (Done !== 1'b1 || Product !== 8'd6) begin
      n_fail++; $display("FAIL held_first_product got=done%b prod%0d want=done1 prod6", Done, Product);
    end
    tick();
    n_checks++;
    if (Busy !== 1'b0 || Done !== 1'b0) begin
      n_fail++; $display("FAIL held_idle_gap got=busy%b done%b want=0/0", Busy, Done);
    end
    tick();
    n_checks++;
    if (Busy !== 1'b1) begin
      n_fail++; $display("FAIL held_reaccept got=busy%b want=1", Busy);
    end
    Start = 1'b0;
    n_checks++;
    if (dones != 1) begin
      n_fail++; $display("FAIL held_done_count got=%0d want=1", dones);
    end
    k = 0;
    while (Done !== 1'b1 && k < 80) begin tick(); k++; end
    n_checks++;
    if (Done !== 1'b1 || Product !== 8'd6) begin
      n_fail++; $display("FAIL held_second_product got=done%b prod%0d want=done1 prod6", Done, Product);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int dones;
    MulA = 8'd7; MulB = 8'd9; Start = 1'b1;
    tick();
    Start = 1'b0;
    tick(); tick();
    Reset = 1'b1;
    tick();
    n_checks++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Product !== 8'd0) begin
      n_fail++; $display("FAIL mid_reset got=busy%b done%b prod%0d want=0/0/0", Busy, Done, Product);
    end
    Reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (Done === 1'b1) dones++;
    end
    n_checks++;
    if (dones != 0 || Product !== 8'd0 || Busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_abort got=dones%0d prod%0d want=dones0 prod0", dones, Product);
    end
    run_op(8'd7, 8'd9, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++)
      run_op(8'($urandom), 8'($urandom), (i % 4) == 0, (i % 3) == 0);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; MulA = '0; MulB = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_start_held();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
